// File: rtl/rv32i_types.sv
// Shared RV32I execution types: ALU opcodes, reservation-station dispatch record,
// CDB broadcast record and the ALU output-queue entry.
package rv32i_types;

    localparam int ROB_IDX_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ops_t;

    typedef struct packed {
        alu_ops_t               operation;
        logic [31:0]            q1_data;
        logic [31:0]            q2_data;
        logic [ROB_IDX_W-1:0]   rob_dest;
    } rs_alu_output_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]   rob_entry;
        logic [31:0]            rd_data;
    } cdb_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]   rob_entry;
        logic [31:0]            rd_data;
    } alu_q_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer ALU: (op, a, b) -> result, zero latency, no handshake.
// Unused opcode encodings return zero so a stray op never leaks stale operand data.
module alu_core
    import rv32i_types::*;
(
    input  alu_ops_t    op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_SLL:  res_o = a_i << shamt;
            ALU_SRL:  res_o = a_i >> shamt;
            ALU_SRA:  res_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:  res_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: res_o = {31'b0, a_i < b_i};
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_AND:  res_o = a_i & b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: dispatch -> in-order result queue -> CDB req/grant; result visible one cycle after dispatch.
// unit_ready credits the in-flight dispatch but not same-cycle pops; optional ALU_EXEC_FLUSH_EN adds a flush input.
module alu_exec_unit
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef ALU_EXEC_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            rs_result_en,
    input  rs_alu_output_t  result,
    output logic            unit_ready,
    output logic            cdb_req,
    output cdb_t            cdb_out,
    input  logic            cdb_grant,
    output logic            overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    alu_q_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        alu_res;
    logic               flush_w;
    logic               full;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occupancy;

`ifdef ALU_EXEC_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    alu_core u_alu_core (
        .op_i  (result.operation),
        .a_i   (result.q1_data),
        .b_i   (result.q2_data),
        .res_o (alu_res)
    );

    assign full = (cnt_q == FULL_CNT);
    assign pop  = cdb_req && cdb_grant;
    // A full queue still accepts a dispatch when the head leaves on the same edge.
    assign push = rs_result_en && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (rs_result_en && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush_w) begin
            mem_q[wr_ptr_q] <= '{rob_entry: result.rob_dest, rd_data: alu_res};
        end
    end

    assign cdb_req      = (cnt_q != '0);
    assign cdb_out      = cdb_req ? cdb_t'(mem_q[rd_ptr_q]) : '0;
    assign overflow_err = ovf_q;

    // Deliberately independent of cdb_grant to keep the arbiter off this timing path.
    assign occupancy  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rs_result_en};
    assign unit_ready = !rst && (occupancy < DEPTH_EXT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: ALU vector table plus queue fill/drain, overflow, reset and flush sequences.
module tb_alu_exec_unit;
    import rv32i_types::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           rs_result_en;
    rs_alu_output_t rs_in;
    logic           unit_ready;
    logic           cdb_req;
    cdb_t           cdb_out;
    logic           cdb_grant;
    logic           overflow_err;

    int n_cmp;
    int n_bad;

    alu_exec_unit #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ALU_EXEC_FLUSH_EN
        .flush        (flush),
`endif
        .rs_result_en (rs_result_en),
        .result       (rs_in),
        .unit_ready   (unit_ready),
        .cdb_req      (cdb_req),
        .cdb_out      (cdb_out),
        .cdb_grant    (cdb_grant),
        .overflow_err (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rob;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] rob);
        rs_in.operation = alu_ops_t'(op);
        rs_in.q1_data   = a;
        rs_in.q2_data   = b;
        rs_in.rob_dest  = rob;
    endtask

    initial begin
        logic       nxt_en;
        logic       exp_rdy;
        int         cnt;
        int         k;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{ALU_ADD,  32'd5,          32'd7,          4'd3,  32'd12};
        vecs[1]  = '{ALU_ADD,  32'hFFFF_FFFF,  32'd1,          4'd1,  32'h0};
        vecs[2]  = '{ALU_SUB,  32'd5,          32'd7,          4'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{ALU_SUB,  32'd0,          32'd1,          4'd4,  32'hFFFF_FFFF};
        vecs[4]  = '{ALU_SLL,  32'd1,          32'd31,         4'd5,  32'h8000_0000};
        vecs[5]  = '{ALU_SLL,  32'd1,          32'd33,         4'd6,  32'h2};
        vecs[6]  = '{ALU_SRL,  32'h8000_0000,  32'd4,          4'd7,  32'h0800_0000};
        vecs[7]  = '{ALU_SRA,  32'h8000_0000,  32'd4,          4'd8,  32'hF800_0000};
        vecs[8]  = '{ALU_SRA,  32'h7FFF_FFF0,  32'd4,          4'd9,  32'h07FF_FFFF};
        vecs[9]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          4'd10, 32'h1};
        vecs[10] = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          4'd11, 32'h0};
        vecs[11] = '{ALU_SLT,  32'd1,          32'hFFFF_FFFF,  4'd12, 32'h0};
        vecs[12] = '{ALU_SLTU, 32'd1,          32'hFFFF_FFFF,  4'd13, 32'h1};
        vecs[13] = '{ALU_XOR,  32'h0000_F0F0,  32'h0000_FF00,  4'd14, 32'h0000_0FF0};
        vecs[14] = '{ALU_OR,   32'h0000_F0F0,  32'h0000_FF00,  4'd15, 32'h0000_FFF0};
        vecs[15] = '{ALU_AND,  32'h0000_F0F0,  32'h0000_FF00,  4'd0,  32'h0000_F000};
        vecs[16] = '{4'hF,     32'd5,          32'd7,          4'd9,  32'h0};

        // Reset with a dispatch pending: nothing may be captured.
        rst = 1'b1;
        flush = 1'b0;
        cdb_grant = 1'b1;
        rs_result_en = 1'b1;
        set_op(ALU_ADD, 32'd1, 32'd2, 4'd7);
        tick();
        tick();
        chk("rst_unit_ready", {31'b0, unit_ready}, 32'h0);
        chk("rst_cdb_req", {31'b0, cdb_req}, 32'h0);
        chk("rst_cdb_data", cdb_out.rd_data, 32'h0);
        chk("rst_cdb_rob", {28'b0, cdb_out.rob_entry}, 32'h0);
        chk("rst_overflow", {31'b0, overflow_err}, 32'h0);
        rst = 1'b0;
        rs_result_en = 1'b0;
        tick();
        chk("idle_cdb_req", {31'b0, cdb_req}, 32'h0);

        // ALU table: dispatch, see it on the CDB next cycle, popped by the held grant.
        for (int i = 0; i < 17; i++) begin
            rs_result_en = 1'b1;
            set_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob);
            tick();
            rs_result_en = 1'b0;
            chk($sformatf("vec%0d_req", i), {31'b0, cdb_req}, 32'h1);
            chk($sformatf("vec%0d_rob", i), {28'b0, cdb_out.rob_entry}, {28'b0, vecs[i].rob});
            chk($sformatf("vec%0d_data", i), cdb_out.rd_data, vecs[i].exp);
            tick();
            chk($sformatf("vec%0d_popped", i), {31'b0, cdb_req}, 32'h0);
        end

        // Fill with grant low, dispatching whenever the previous cycle's unit_ready allowed it.
        cdb_grant = 1'b0;
        cnt = 0;
        k = 0;
        nxt_en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rs_result_en = nxt_en;
            set_op(ALU_ADD, k, 32'd100, 4'(k));
            #1;
            exp_rdy = ((cnt + int'(nxt_en)) < 4);
            chk($sformatf("fill%0d_ready", c), {31'b0, unit_ready}, {31'b0, exp_rdy});
            tick();
            if (rs_result_en) begin
                cnt++;
                k++;
            end
            nxt_en = exp_rdy;
        end
        rs_result_en = 1'b0;
        chk("fill_count", cnt, 4);
        chk("fill_overflow", {31'b0, overflow_err}, 32'h0);
        chk("fill_req", {31'b0, cdb_req}, 32'h1);
        cdb_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d_rob", i), {28'b0, cdb_out.rob_entry}, i);
            chk($sformatf("drain%0d_data", i), cdb_out.rd_data, 100 + i);
            tick();
        end
        chk("drain_empty", {31'b0, cdb_req}, 32'h0);

        // Full queue: push+pop on one edge, then a dropped push.
        cdb_grant = 1'b0;
        rs_result_en = 1'b1;
        for (int i = 4; i < 8; i++) begin
            set_op(ALU_ADD, i, 32'd0, 4'(i));
            tick();
        end
        set_op(ALU_ADD, 32'd8, 32'd0, 4'd8);
        cdb_grant = 1'b1;
        tick();
        rs_result_en = 1'b0;
        cdb_grant = 1'b0;
        #1;
        chk("pp_full_ready", {31'b0, unit_ready}, 32'h0);
        chk("pp_head_rob", {28'b0, cdb_out.rob_entry}, 32'd5);
        chk("pp_no_overflow", {31'b0, overflow_err}, 32'h0);
        rs_result_en = 1'b1;
        set_op(ALU_ADD, 32'd9, 32'd0, 4'd9);
        tick();
        rs_result_en = 1'b0;
        chk("ovf_set", {31'b0, overflow_err}, 32'h1);
        chk("ovf_head_rob", {28'b0, cdb_out.rob_entry}, 32'd5);
        cdb_grant = 1'b1;
        for (int i = 5; i < 9; i++) begin
            #1;
            chk($sformatf("wrap%0d_rob", i), {28'b0, cdb_out.rob_entry}, i);
            chk($sformatf("wrap%0d_data", i), cdb_out.rd_data, i);
            tick();
        end
        chk("wrap_empty", {31'b0, cdb_req}, 32'h0);
        chk("ovf_sticky", {31'b0, overflow_err}, 32'h1);

        // Reset with 3 queued entries and a same-edge dispatch.
        cdb_grant = 1'b0;
        rs_result_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            set_op(ALU_ADD, i, 32'd0, 4'(i));
            tick();
        end
        rst = 1'b1;
        set_op(ALU_ADD, 32'd10, 32'd0, 4'd10);
        tick();
        rst = 1'b0;
        rs_result_en = 1'b0;
        chk("mrst_req", {31'b0, cdb_req}, 32'h0);
        chk("mrst_data", cdb_out.rd_data, 32'h0);
        chk("mrst_rob", {28'b0, cdb_out.rob_entry}, 32'h0);
        chk("mrst_ovf", {31'b0, overflow_err}, 32'h0);
        rs_result_en = 1'b1;
        set_op(ALU_ADD, 32'd1, 32'd1, 4'd11);
        tick();
        rs_result_en = 1'b0;
        cdb_grant = 1'b1;
        chk("post_rst_req", {31'b0, cdb_req}, 32'h1);
        chk("post_rst_rob", {28'b0, cdb_out.rob_entry}, 32'd11);
        chk("post_rst_data", cdb_out.rd_data, 32'd2);
        tick();
        chk("post_rst_sole", {31'b0, cdb_req}, 32'h0);

`ifdef ALU_EXEC_FLUSH_EN
        // Flush with 2 queued and a same-edge dispatch.
        cdb_grant = 1'b0;
        rs_result_en = 1'b1;
        for (int i = 1; i < 3; i++) begin
            set_op(ALU_ADD, i, 32'd0, 4'(i));
            tick();
        end
        flush = 1'b1;
        set_op(ALU_ADD, 32'd3, 32'd0, 4'd3);
        tick();
        flush = 1'b0;
        rs_result_en = 1'b0;
        #1;
        chk("flush_req", {31'b0, cdb_req}, 32'h0);
        chk("flush_ready", {31'b0, unit_ready}, 32'h1);
        rs_result_en = 1'b1;
        set_op(ALU_ADD, 32'd3, 32'd4, 4'd12);
        tick();
        rs_result_en = 1'b0;
        cdb_grant = 1'b1;
        chk("post_flush_rob", {28'b0, cdb_out.rob_entry}, 32'd12);
        chk("post_flush_data", cdb_out.rd_data, 32'd7);
        tick();
        chk("post_flush_empty", {31'b0, cdb_req}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
